serial_subtract_ctrl: RTL

- Bit-serial multi-bit subtractor controller; computes DIFF = A - B over WIDTH clock cycles.
- Per cycle it sequences one bit pair, LSB first, through a 1-bit subtract cell (two half-subtractor stages) with a registered borrow chain.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades area for latency: one subtract cell is reused WIDTH times per operation.

---
 rtl/serial_subtract_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial A - B controller: one subtract cell reused WIDTH times, LSB first, with valid/ready on both sides.
// Optional signed-overflow output is enabled by defining SERSUB_OVF_EN.
module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_brw;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;

    logic             w_d;
    logic             w_brw_next;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_res_next;

`ifdef SERSUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    // Two cascaded half-subtractors: the borrow chain is the only carried state between bits.
    assign w_d        = r_a_sh[0] ^ r_b_sh[0] ^ r_brw;
    assign w_brw_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_brw);
    assign w_res_next = WIDTH'({w_d, r_res} >> 1);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept   = (r_state == S_IDLE) && in_valid && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (clr) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_brw    <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
`ifdef SERSUB_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else if (clr) begin
            // Aborts drop the partial result but keep the last delivered diff/borrow_out.
            r_brw <= 1'b0;
            r_cnt <= '0;
`ifdef SERSUB_OVF_EN
            r_ovf <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_res  <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
`ifdef SERSUB_OVF_EN
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
`endif
        end else if (r_state == S_RUN) begin
            r_res  <= w_res_next;
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_brw  <= w_brw_next;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_diff   <= w_res_next;
                r_borrow <= w_brw_next;
`ifdef SERSUB_OVF_EN
                r_ovf    <= (r_a_msb != r_b_msb) & (w_res_next[WIDTH-1] != r_a_msb);
`endif
            end
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow;
`ifdef SERSUB_OVF_EN
    assign ovf        = r_ovf;
`endif

endmodule
